// File: rtl/dec_scan_ctrl.sv
// Scan sequencer for a 3-to-8 decoder: walks the masked codes in ascending
// order, holding enable for a programmable dwell with one blank cycle between codes.
module dec_scan_ctrl #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               oneshot,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_BLANK = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic               oneshot_q, oneshot_d;

    logic               start_ok;
    logic               dwell_end;
    logic               last_code;
    logic [7:0]         upper;
    logic               has_above;
    logic [DWELL_W-1:0] dwell_eff;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Mask bits strictly above the current code (empty when sel is 7)
    assign upper     = mask_q & ~((8'd2 << sel_q) - 8'd1);
    assign has_above = |upper;
    assign start_ok  = start && (mask != 8'd0);
    assign dwell_end = (cnt_q == dwell_q);
    assign last_code = oneshot_q && !has_above;
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= 3'd0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cnt_q     <= '0;
            dwell_q   <= '0;
            mask_q    <= 8'd0;
            oneshot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
            cnt_q     <= cnt_d;
            dwell_q   <= dwell_d;
            mask_q    <= mask_d;
            oneshot_q <= oneshot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_DWELL;
            S_DWELL: begin
                if (stop)           state_d = S_IDLE;
                else if (dwell_end) state_d = last_code ? S_IDLE : S_BLANK;
            end
            S_BLANK: state_d = stop ? S_IDLE : S_DWELL;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and scan context
    always_comb begin
        sel_d     = sel_q;
        en_d      = en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        cnt_d     = cnt_q;
        dwell_d   = dwell_q;
        mask_d    = mask_q;
        oneshot_d = oneshot_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    mask_d    = mask;
                    oneshot_d = oneshot;
                    dwell_d   = dwell_eff;
                    sel_d     = lowest_bit(mask);
                    en_d      = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = DWELL_W'(1);
                end
            end
            S_DWELL: begin
                if (stop) begin
                    en_d   = 1'b0;
                    busy_d = 1'b0;
                end else if (dwell_end) begin
                    en_d = 1'b0;
                    if (last_code) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            S_BLANK: begin
                if (stop) begin
                    en_d   = 1'b0;
                    busy_d = 1'b0;
                end else begin
                    en_d  = 1'b1;
                    cnt_d = DWELL_W'(1);
                    if (has_above) begin
                        sel_d = lowest_bit(upper);
                    end else begin
                        sel_d  = lowest_bit(mask_q);
                        wrap_d = 1'b1;
                    end
                end
            end
            default: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign sel  = sel_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: directed scenarios plus randomized scans compared
// against a per-cycle trace built from the scan rules.
module tb_dec_scan_ctrl;

    localparam int unsigned DWELL_W = 16;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic               oneshot;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic               en;
    logic               busy;
    logic               done;
    logic               wrap;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected trace entries: {sel[2:0], en, busy, done, wrap}
    logic [6:0] exp_q[$];

    dec_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .oneshot (oneshot),
        .mask    (mask),
        .dwell   (dwell),
        .sel     (sel),
        .en      (en),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry j is the output state right after the j-th edge, edge 0 taking the start.
    function automatic void build_trace(input logic [7:0] m, input int d, input bit os, input int ncyc);
        int codes[$];
        int dd;
        int pass;
        exp_q.delete();
        for (int i = 0; i < 8; i++) if (m[i]) codes.push_back(i);
        if (codes.size() == 0) return;
        dd   = (d == 0) ? 1 : d;
        pass = 0;
        while (exp_q.size() < ncyc) begin
            foreach (codes[ci]) begin
                for (int t = 0; t < dd; t++)
                    exp_q.push_back({3'(codes[ci]), 1'b1, 1'b1, 1'b0,
                                     1'((t == 0) && (ci == 0) && (pass > 0))});
                if (os && (ci == codes.size() - 1)) begin
                    exp_q.push_back({3'(codes[ci]), 4'b0010});
                    while (exp_q.size() < ncyc) exp_q.push_back({3'(codes[ci]), 4'b0000});
                    return;
                end
                exp_q.push_back({3'(codes[ci]), 4'b0100});
            end
            pass++;
        end
    endfunction

    // Called just after a negedge; returns at the negedge following the start edge.
    task automatic start_scan(input logic [7:0] m, input int d, input bit os);
        mask    = m;
        dwell   = DWELL_W'(d);
        oneshot = os;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
        mask = 8'd0; dwell = '0;
        #2;
        n_checks++;
        if ({sel, en, busy, done, wrap} !== 7'd0)
            $display("FAIL reset_values: got %b expected %b", {sel, en, busy, done, wrap}, 7'd0);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({sel, en, busy, done, wrap} !== 7'd0)
            $display("FAIL reset_release_idle: got %b expected %b", {sel, en, busy, done, wrap}, 7'd0);
        else n_pass++;
    endtask

    task automatic test_null_start();
        mask = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sel, en, busy} !== 5'd0)
            $display("FAIL null_start: got sel=%0d en=%b busy=%b expected all 0", sel, en, busy);
        else n_pass++;
        mask = 8'h10; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if ({sel, en, busy} !== {3'd4, 1'b1, 1'b1})
            $display("FAIL start_beats_stop_idle: got sel=%0d en=%b busy=%b expected sel=4 en=1 busy=1",
                     sel, en, busy);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_oneshot();
        int sel_e [9] = '{2, 2, 2, 2, 5, 5, 5, 5, 5};
        bit en_e  [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
        bit busy_e[9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        bit done_e[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        start_scan(8'b0010_0100, 3, 1'b1);
        for (int j = 0; j < 9; j++) begin
            if (j > 0) @(negedge clk);
            n_checks++;
            if ({sel, en, busy, done, wrap} !== {3'(sel_e[j]), en_e[j], busy_e[j], done_e[j], 1'b0})
                $display("FAIL oneshot_E%0d: got sel=%0d en=%b busy=%b done=%b wrap=%b expected sel=%0d en=%b busy=%b done=%b wrap=0",
                         j, sel, en, busy, done, wrap, sel_e[j], en_e[j], busy_e[j], done_e[j]);
            else n_pass++;
        end
    endtask

    task automatic test_continuous();
        build_trace(8'b0010_0100, 3, 1'b0, 24);
        start_scan(8'b0010_0100, 3, 1'b0);
        for (int j = 0; j < 24; j++) begin
            if (j > 0) @(negedge clk);
            n_checks++;
            if ({sel, en, busy, done, wrap} !== exp_q[j])
                $display("FAIL continuous_E%0d: got %b expected %b", j, {sel, en, busy, done, wrap}, exp_q[j]);
            else n_pass++;
            n_checks++;
            if (wrap !== ((j == 8) || (j == 16)))
                $display("FAIL continuous_wrap_E%0d: got %b expected %b", j, wrap, (j == 8) || (j == 16));
            else n_pass++;
        end
        go_idle();
    endtask

    task automatic test_zero_dwell();
        build_trace(8'hFF, 0, 1'b1, 18);
        start_scan(8'hFF, 0, 1'b1);
        for (int j = 0; j < 18; j++) begin
            if (j > 0) @(negedge clk);
            n_checks++;
            if ({sel, en, busy, done, wrap} !== exp_q[j])
                $display("FAIL zero_dwell_E%0d: got %b expected %b", j, {sel, en, busy, done, wrap}, exp_q[j]);
            else n_pass++;
            n_checks++;
            if (done !== (j == 15))
                $display("FAIL zero_dwell_done_E%0d: got %b expected %b", j, done, j == 15);
            else n_pass++;
        end
    endtask

    task automatic test_stop();
        start_scan(8'b0010_0100, 3, 1'b0);
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if ({sel, en, busy, done, wrap} !== {3'd5, 4'b0000})
            $display("FAIL stop_in_dwell: got %b expected %b", {sel, en, busy, done, wrap}, {3'd5, 4'b0000});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({en, busy, done, wrap} !== 4'b0000)
            $display("FAIL stop_stays_idle: got %b expected 0000", {en, busy, done, wrap});
        else n_pass++;
        start_scan(8'b0010_0100, 3, 1'b0);
        n_checks++;
        if ({sel, en, busy} !== {3'd2, 1'b1, 1'b1})
            $display("FAIL restart_after_stop: got sel=%0d en=%b busy=%b expected sel=2 en=1 busy=1", sel, en, busy);
        else n_pass++;
        repeat (7) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if ({sel, en, busy, done, wrap} !== {3'd5, 4'b0000})
            $display("FAIL stop_in_blank_no_wrap: got %b expected %b", {sel, en, busy, done, wrap}, {3'd5, 4'b0000});
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] m;
        int         d;
        bit         os;
        for (int it = 0; it < 20; it++) begin
            m  = 8'($urandom_range(1, 255));
            d  = int'($urandom_range(0, 4));
            os = 1'($urandom_range(0, 1));
            build_trace(m, d, os, 40);
            start_scan(m, d, os);
            for (int j = 0; j < 40; j++) begin
                if (j > 0) @(negedge clk);
                n_checks++;
                if ({sel, en, busy, done, wrap} !== exp_q[j])
                    $display("FAIL random_it%0d_E%0d: mask=%h dwell=%0d oneshot=%b got %b expected %b",
                             it, j, m, d, os, {sel, en, busy, done, wrap}, exp_q[j]);
                else n_pass++;
                mask    = 8'($urandom);
                dwell   = DWELL_W'($urandom_range(0, 7));
                oneshot = 1'($urandom_range(0, 1));
                start   = exp_q[j][2] ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            start = 1'b0;
            go_idle();
            n_checks++;
            if ({en, busy} !== 2'b00)
                $display("FAIL random_it%0d_idle: got en=%b busy=%b expected 0 0", it, en, busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_scan();
        start_scan(8'b0010_0100, 3, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sel, en, busy, done, wrap} !== 7'd0)
            $display("FAIL reset_mid_scan_async: got %b expected %b", {sel, en, busy, done, wrap}, 7'd0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sel, en, busy, done, wrap} !== 7'd0)
            $display("FAIL reset_mid_scan_idle: got %b expected %b", {sel, en, busy, done, wrap}, 7'd0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_null_start();
        test_oneshot();
        test_continuous();
        test_zero_dwell();
        test_stop();
        test_random();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
